// File: rtl/light_mode_ctrl_if.sv
// Signal bundle between the push-button decoder / occupancy sensor and the
// lamp mode controller.
interface light_mode_ctrl_if;
  logic A;
  logic B;
  logic presence;
  logic lamp;
  logic manual;

  modport master (
    output A,
    output B,
    output presence,
    input  lamp,
    input  manual
  );

  modport slave (
    input  A,
    input  B,
    input  presence,
    output lamp,
    output manual
  );
endinterface

// File: rtl/light_mode_ctrl.sv
// Lamp mode controller: auto mode follows occupancy with a hold timer,
// manual mode toggles the lamp with short presses; long press swaps modes.
module light_mode_ctrl #(
  parameter int unsigned AUTO_OFF_T = 30000,
  parameter int unsigned CNT_W      = 16
) (
  input logic               clk,
  input logic               rst,
  light_mode_ctrl_if.slave  io
);

  typedef enum logic [1:0] {
    AUTO_OFF = 2'b00,
    AUTO_ON  = 2'b01,
    MAN_OFF  = 2'b10,
    MAN_ON   = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(AUTO_OFF_T - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lamp_q, lamp_d;
  logic             manual_q, manual_d;

  function automatic logic lamp_of(input state_e s);
    return (s == AUTO_ON) || (s == MAN_ON);
  endfunction

  function automatic logic manual_of(input state_e s);
    return (s == MAN_OFF) || (s == MAN_ON);
  endfunction

  // State, hold counter and output registers; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= AUTO_OFF;
      cnt_q    <= CNT_ZERO;
      lamp_q   <= 1'b0;
      manual_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lamp_q   <= lamp_d;
      manual_q <= manual_d;
    end
  end

  // Next-state logic; A outranks presence and B in every state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      AUTO_OFF: begin
        if (io.A) begin
          state_d = MAN_OFF;
        end else if (io.presence) begin
          state_d = AUTO_ON;
          cnt_d   = HOLD_LOAD;
        end else begin
          state_d = AUTO_OFF;
        end
      end
      AUTO_ON: begin
        if (io.A) begin
          state_d = MAN_ON;
        end else if (io.presence) begin
          cnt_d = HOLD_LOAD;
        end else if (cnt_q == CNT_ZERO) begin
          state_d = AUTO_OFF;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      MAN_OFF: begin
        if (io.A) begin
          state_d = AUTO_OFF;
          cnt_d   = CNT_ZERO;
        end else if (io.B) begin
          state_d = MAN_ON;
        end else begin
          state_d = MAN_OFF;
        end
      end
      MAN_ON: begin
        if (io.A) begin
          state_d = AUTO_OFF;
          cnt_d   = CNT_ZERO;
        end else if (io.B) begin
          state_d = MAN_OFF;
        end else begin
          state_d = MAN_ON;
        end
      end
      default: begin
        state_d = AUTO_OFF;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Outputs are flopped copies of the next-state decode, so they track state_q exactly.
  always_comb begin
    lamp_d   = lamp_of(state_d);
    manual_d = manual_of(state_d);
  end

  assign io.lamp   = lamp_q;
  assign io.manual = manual_q;

endmodule

// File: tb/tb_light_mode_ctrl.sv
// Directed scoreboard bench for light_mode_ctrl with an 8-cycle hold time.
module tb_light_mode_ctrl;

  typedef struct {
    logic  lamp;
    logic  manual;
    string name;
  } exp_t;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  exp_t sb_q[$];

  light_mode_ctrl_if bus ();

  light_mode_ctrl #(
    .AUTO_OFF_T(8),
    .CNT_W     (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic al, input logic am,
                       input logic el, input logic em);
    vectors++;
    if ({al, am} !== {el, em}) begin
      miscompares++;
      $display("FAIL %s: lamp,manual got %b,%b expected %b,%b at %0t",
               nm, al, am, el, em, $time);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic cyc(input logic a, input logic b, input logic p,
                     input logic el, input logic em, input string nm);
    exp_t e;
    @(negedge clk);
    bus.A        = a;
    bus.B        = b;
    bus.presence = p;
    e.lamp   = el;
    e.manual = em;
    e.name   = nm;
    sb_q.push_back(e);
  endtask

  // Monitor: one registered output sample per clock edge.
  initial begin
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check(e.name, bus.lamp, bus.manual, e.lamp, e.manual);
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() > 0 && n < 10) begin
      @(posedge clk);
      #2;
      n++;
    end
    vectors++;
    if (sb_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    bus.A        = 1'b0;
    bus.B        = 1'b0;
    bus.presence = 1'b1;
    rst          = 1'b1;
    #3;
    check("reset_state", bus.lamp, bus.manual, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_ignores_inputs", bus.lamp, bus.manual, 1'b0, 1'b0);
    @(negedge clk);
    rst          = 1'b0;
    bus.presence = 1'b0;

    // Single presence pulse: 8 cycles of lamp, then off.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle");
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "pres_on");
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "hold");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "hold_expire");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "stay_off");

    // Retrigger at cycle 5: lamp high for 13 continuous cycles.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "retrig_c0");
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "retrig_gap");
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "retrig_c5");
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "retrig_hold");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "retrig_expire");

    // Auto-on to manual keeps the lamp; presence ignored; B toggles.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "auto_on");
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, "a_to_man_on");
    for (int i = 0; i < 20; i++) begin
      logic [4:0] iv;
      iv = 5'(i);
      cyc(1'b0, 1'b0, iv[0], 1'b1, 1'b1, "man_pres_ignored");
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "b_to_man_off");
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "b_to_man_on");

    // A and B together in MAN_ON: A wins, auto re-lights one cycle later.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "ab_to_auto_off");
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "relight");
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "relight_hold");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "relight_expire");

    // B ignored in auto; A beats presence; A held acts every cycle.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "b_ignored_auto");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "a_pres_man_off");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "man_off_pres_ign");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "a_to_auto_off");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "a_held_1");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "a_held_2");

    // Reset mid-hold at cnt=4.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "hold_start");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "hold_to_4");
    drain();
    rst          = 1'b1;
    bus.presence = 1'b1;
    #1;
    check("async_rst_hold", bus.lamp, bus.manual, 1'b0, 1'b0);
    @(negedge clk);
    rst          = 1'b0;
    bus.presence = 1'b0;
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "post_rst_off");

    // Reset in MAN_ON.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "to_man_off");
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "to_man_on");
    drain();
    rst = 1'b1;
    #1;
    check("async_rst_man_on", bus.lamp, bus.manual, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "post_rst_b_ign");
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "post_rst_pres");
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
